// File: rtl/shift_seq_pkg.sv
// Shared types and defaults for the multi-cycle shift sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shift_seq_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int AMT_W_DEF  = 4;

   typedef enum logic [1:0] {
      SH_PASS = 2'b00,
      SH_LSL  = 2'b01,
      SH_LSR  = 2'b10,
      SH_ASR  = 2'b11
   } shift_op_e;

   // 2'b11 is the spare code; the sequencer forces it back to S_IDLE.
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_e;

endpackage

// File: rtl/shift_step.sv
// Single-position shift stage: LSL, LSR, ASR (sign replicated) or identity.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no handshake.
module shift_step
   import shift_seq_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [DATA_W-1:0] d,
   input  logic [1:0]        op,
   output logic [DATA_W-1:0] q
);

   // One-bit move in the direction selected by op.
   always_comb begin
      q = d;
      case (op)
         SH_LSL:  q = {d[DATA_W-2:0], 1'b0};
         SH_LSR:  q = {1'b0, d[DATA_W-1:1]};
         SH_ASR:  q = {d[DATA_W-1], d[DATA_W-1:1]};
         default: q = d;
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// Variable-amount LSL/LSR/ASR built from one shift_step iterated once per clock.
// Latency: result valid amt+2 cycles after accept (2 for pass/amt 0); SHIFT_SEQ_EARLY_EXIT_EN stops at a fixed point.
// Backpressure: result held in DONE until out_ready; start_ready only in IDLE.
module shift_sequencer
   import shift_seq_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int AMT_W  = AMT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_valid,
   output logic              start_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [1:0]        shift_op,
   input  logic [AMT_W-1:0]  shift_amt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy
);

   localparam logic [AMT_W-1:0] CNT_ONE = 1;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d, step_d;
   logic [AMT_W-1:0]  count_q, count_d;
   logic [1:0]        op_q, op_d;
   logic              fixed_pt;

   shift_step #(.DATA_W(DATA_W)) u_step (
      .d  (data_q),
      .op (op_q),
      .q  (step_d)
   );

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
   // Further steps cannot change the value, so the remaining count is skipped.
   assign fixed_pt = (step_d == data_q);
`else
   assign fixed_pt = 1'b0;
`endif

   // The result register is the output; no input reaches out_data combinationally.
   assign out_data = data_q;

   // State, operand, op and remaining-count registers; reset aborts any operation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         count_q <= '0;
         op_q    <= 2'b00;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         count_q <= count_d;
         op_q    <= op_d;
      end
   end

   // Next-state, datapath update and state-decoded handshake outputs.
   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      count_d     = count_q;
      op_d        = op_q;
      start_ready = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b0;
      case (state_q)
         S_IDLE: begin
            start_ready = 1'b1;
            if (start_valid) begin
               data_d  = in_data;
               op_d    = shift_op;
               count_d = (shift_op == SH_PASS) ? '0 : shift_amt;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if ((count_q == '0) || fixed_pt) begin
               count_d = '0;
               state_d = S_DONE;
            end else begin
               data_d  = step_d;
               count_d = count_q - CNT_ONE;
            end
         end
         S_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed scenarios plus randomized operations.
// Expected results and latencies come from an arithmetic shift model; honours SHIFT_SEQ_EARLY_EXIT_EN.
// Consumer stalls are injected to exercise result holding in DONE.
module tb_shift_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start_valid = 1'b0;
   logic        start_ready;
   logic [15:0] in_data = '0;
   logic [1:0]  shift_op = 2'b00;
   logic [3:0]  shift_amt = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic        busy;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   shift_sequencer #(.DATA_W(16), .AMT_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .in_data     (in_data),
      .shift_op    (shift_op),
      .shift_amt   (shift_amt),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Shift d by n positions in one arithmetic operation.
   function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [1:0] op, input int n);
      logic [15:0] r;
      case (op)
         2'b01:   r = d << n;
         2'b10:   r = d >> n;
         2'b11:   r = $signed(d) >>> n;
         default: r = d;
      endcase
      return r;
   endfunction

   function automatic int ref_amt(input logic [1:0] op, input logic [3:0] amt);
      return (op == 2'b00) ? 0 : int'(amt);
   endfunction

   // Edges counted from the accept edge (inclusive) until out_valid is seen.
   function automatic int ref_lat(input logic [15:0] d, input logic [1:0] op, input logic [3:0] amt);
      int n;
      n = ref_amt(op, amt);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
      for (int i = 0; i < n; i++) begin
         if (ref_shift(d, op, i) == ref_shift(d, op, i + 1)) begin
            n = i;
            break;
         end
      end
`endif
      return n + 2;
   endfunction

   // Issue one request from a negedge, wait for the result, stall, then drain.
   task automatic run_op(input string tag, input logic [15:0] d, input logic [1:0] op,
                         input logic [3:0] amt, input int stall);
      logic [15:0] exp_d;
      int          exp_lat;
      int          lat;
      logic        busy_ok;
      logic        hold_ok;
      exp_d   = ref_shift(d, op, ref_amt(op, amt));
      exp_lat = ref_lat(d, op, amt);
      chk({tag, ":start_ready"}, start_ready, 1);
      in_data     = d;
      shift_op    = op;
      shift_amt   = amt;
      start_valid = 1'b1;
      out_ready   = (stall == 0);
      lat     = 0;
      busy_ok = 1'b1;
      while (lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (out_valid === 1'b1) break;
         start_valid = 1'($urandom);
         in_data     = 16'($urandom);
         shift_op    = 2'($urandom);
         shift_amt   = 4'($urandom);
      end
      start_valid = 1'b0;
      chk({tag, ":latency"}, lat, exp_lat);
      chk({tag, ":data"}, out_data, exp_d);
      chk({tag, ":busy"}, busy_ok, 1);
      hold_ok = 1'b1;
      for (int i = 0; i < stall; i++) begin
         start_valid = 1'($urandom);
         @(posedge clk);
         @(negedge clk);
         if (out_valid !== 1'b1 || out_data !== exp_d || start_ready !== 1'b0) hold_ok = 1'b0;
      end
      start_valid = 1'b0;
      if (stall > 0) chk({tag, ":hold"}, hold_ok, 1);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk({tag, ":drain_valid"}, out_valid, 0);
      chk({tag, ":drain_ready"}, start_ready, 1);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [15:0] rd;
      logic [1:0]  rop;
      logic [3:0]  ramt;

      // Reset held three cycles, then idle outputs.
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rst:start_ready", start_ready, 1);
      chk("rst:out_valid", out_valid, 0);
      chk("rst:out_data", out_data, 16'h0000);
      chk("rst:busy", busy, 0);
      @(negedge clk);

      run_op("lsl", 16'h0001, 2'b01, 4'd4, 0);
      run_op("asr", 16'h8004, 2'b11, 4'd3, 0);
      run_op("pass", 16'h8004, 2'b00, 4'd7, 0);
      run_op("bp_lsr", 16'hFFFF, 2'b10, 4'd15, 5);

      // Reset mid-run aborts asynchronously.
      in_data = 16'h1234; shift_op = 2'b01; shift_amt = 4'd10; start_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("midrst:busy_before", busy, 1);
      reset = 1'b1;
      #1;
      chk("midrst:start_ready", start_ready, 1);
      chk("midrst:out_valid", out_valid, 0);
      chk("midrst:out_data", out_data, 16'h0000);
      chk("midrst:busy", busy, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run_op("after_rst", 16'h00FF, 2'b10, 4'd4, 0);

      run_op("early_exit", 16'h0003, 2'b10, 4'd15, 0);
      run_op("asr_neg_fix", 16'hFFFF, 2'b11, 4'd9, 1);
      run_op("lsl_zero", 16'h0000, 2'b01, 4'd12, 0);

      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 3))
            0:       rd = 16'h0000;
            1:       rd = 16'hFFFF;
            2:       rd = 16'($urandom_range(0, 15));
            default: rd = 16'($urandom);
         endcase
         rop  = 2'($urandom);
         ramt = 4'($urandom);
         run_op("rand", rd, rop, ramt, $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
